volume_level_tracker: RTL and testbench

- Upstream feeder of the seven-segment display stage.
- Consumes 12-bit microphone samples at the sample strobe rate.
- Finds the peak amplitude over a fixed window of samples and quantises it to a 4-bit level `num` (0..15).
- Classifies that level into the 2-bit `LIRO_state` band code; both feed the display driver directly.

---
 rtl/volume_pkg.sv | 27 ++
 rtl/volume_level_tracker_if.sv | 19 +
 rtl/volume_level_tracker_window_peak_detector.sv | 55 +++++
 rtl/volume_level_tracker.sv | 99 +++++++++
 tb/tb_volume_level_tracker.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/volume_pkg.sv
// Shared encodings, thresholds and level/band helpers for the volume level tracker
// and the downstream display control.
package volume_pkg;

  typedef enum logic [1:0] {
    LIRO_LOW  = 2'd0,
    LIRO_MID  = 2'd1,
    LIRO_HIGH = 2'd2,
    LIRO_CLIP = 2'd3
  } liro_e;

  localparam logic [3:0]  MID_LEVEL  = 4'd6;
  localparam logic [3:0]  HIGH_LEVEL = 4'd11;
  localparam logic [11:0] ADC_MAX    = 12'd4095;

  // Top four bits of the 11-bit amplitude give the 0..15 display level.
  function automatic logic [3:0] level_of(input logic [10:0] peak);
    return peak[10:7];
  endfunction

  function automatic liro_e band_of(input logic [3:0] level);
    if (level >= HIGH_LEVEL) return LIRO_HIGH;
    if (level >= MID_LEVEL)  return LIRO_MID;
    return LIRO_LOW;
  endfunction

endpackage

// File: rtl/volume_level_tracker_if.sv
// Sample-in / level-out bundle between the microphone front end, the tracker and
// the seven-segment display driver.
interface volume_level_tracker_if;
    logic        sample_valid;
    logic [11:0] mic_in;
    logic [3:0]  num;
    logic [1:0]  LIRO_state;
    logic        level_valid;

    modport master (
        output sample_valid, mic_in,
        input  num, LIRO_state, level_valid
    );

    modport slave (
        input  sample_valid, mic_in,
        output num, LIRO_state, level_valid
    );
endinterface

// File: rtl/volume_level_tracker_window_peak_detector.sv
// Counts accepted samples, tracks peak amplitude and clip over each window and
// presents the closing window's final peak/clip alongside a combinational close pulse.
module window_peak_detector
    import volume_pkg::*;
#(
    parameter int unsigned WINDOW_SAMPLES = 4000,
    parameter int unsigned MIC_OFFSET     = 2048
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic        close,
    output logic [10:0] final_peak,
    output logic        final_clip
);
    localparam int unsigned CntW   = $clog2(WINDOW_SAMPLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(WINDOW_SAMPLES - 1);
    localparam logic [12:0] Offset = 13'(MIC_OFFSET);

    logic [CntW-1:0] count;
    logic [10:0]     peak;
    logic            clip;
    logic [12:0]     diff;
    logic [10:0]     amp;

    always_comb begin
        diff = 13'd0;
        if ({1'b0, mic_in} > Offset) diff = {1'b0, mic_in} - Offset;
        amp = (diff > 13'd2047) ? 11'd2047 : diff[10:0];
    end

    // The closing sample itself is folded into the reported window result.
    assign close      = sample_valid && (count == LastCnt);
    assign final_peak = (amp > peak) ? amp : peak;
    assign final_clip = clip | (mic_in == ADC_MAX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
            peak  <= '0;
            clip  <= 1'b0;
        end else if (sample_valid) begin
            if (close) begin
                count <= '0;
                peak  <= '0;
                clip  <= 1'b0;
            end else begin
                count <= count + 1'b1;
                peak  <= final_peak;
                clip  <= final_clip;
            end
        end
    end
endmodule

// File: rtl/volume_level_tracker.sv
// Windowed peak volume meter: quantises each window's peak to a 0..15 level and band code.
// Optional decaying peak-hold display enabled by defining VOLUME_PEAK_HOLD_EN.
module volume_level_tracker
    import volume_pkg::*;
#(
    parameter int unsigned WINDOW_SAMPLES = 4000,
    parameter int unsigned MIC_OFFSET     = 2048,
    parameter int unsigned HOLD_WINDOWS   = 3
) (
    input logic             CLK,
    input logic             RESET,
    volume_level_tracker_if.slave bus
);
    if (WINDOW_SAMPLES < 2) begin : g_bad_window
        $error("WINDOW_SAMPLES must be at least 2");
    end
    if (HOLD_WINDOWS < 1) begin : g_bad_hold
        $error("HOLD_WINDOWS must be at least 1");
    end

    logic        close;
    logic [10:0] final_peak;
    logic        final_clip;
    logic [3:0]  level;
    logic [3:0]  shown;

    logic [3:0]  num_q;
    liro_e       state_q;
    logic        valid_q;

    window_peak_detector #(
        .WINDOW_SAMPLES (WINDOW_SAMPLES),
        .MIC_OFFSET     (MIC_OFFSET)
    ) u_detector (
        .CLK          (CLK),
        .RESET        (RESET),
        .sample_valid (bus.sample_valid),
        .mic_in       (bus.mic_in),
        .close        (close),
        .final_peak   (final_peak),
        .final_clip   (final_clip)
    );

    assign level = level_of(final_peak);

`ifdef VOLUME_PEAK_HOLD_EN
    localparam int unsigned HoldW = $clog2(HOLD_WINDOWS + 1);

    logic [3:0]       disp_q, disp_d;
    logic [HoldW-1:0] hold_q, hold_d;

    // Louder windows take over immediately; quieter ones decay one step per hold period.
    always_comb begin
        disp_d = disp_q;
        hold_d = hold_q;
        if (level >= disp_q) begin
            disp_d = level;
            hold_d = '0;
        end else if (hold_q == HoldW'(HOLD_WINDOWS - 1)) begin
            disp_d = disp_q - 1'b1;
            hold_d = '0;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            disp_q <= '0;
            hold_q <= '0;
        end else if (close) begin
            disp_q <= disp_d;
            hold_q <= hold_d;
        end
    end

    assign shown = disp_d;
`else
    assign shown = level;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            num_q   <= '0;
            state_q <= LIRO_LOW;
            valid_q <= 1'b0;
        end else begin
            valid_q <= close;
            if (close) begin
                num_q   <= shown;
                state_q <= final_clip ? LIRO_CLIP : band_of(shown);
            end
        end
    end

    assign bus.num         = num_q;
    assign bus.LIRO_state  = state_q;
    assign bus.level_valid = valid_q;
endmodule

// File: tb/tb_volume_level_tracker.sv
// Directed, table-driven bench for volume_level_tracker with a 4-sample window;
// the peak-hold sequence runs instead of the table when VOLUME_PEAK_HOLD_EN is defined.
module tb_volume_level_tracker;
    localparam int unsigned W = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    volume_level_tracker_if bus ();

    volume_level_tracker #(
        .WINDOW_SAMPLES (W),
        .MIC_OFFSET     (2048),
        .HOLD_WINDOWS   (3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0][11:0] s;
        int               gap;
        logic [3:0]       exp_num;
        logic [1:0]       exp_state;
    } vec_t;

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                                input int gap, input int n, input int st);
        vec_t v;
        v.s[0] = 12'(s0);
        v.s[1] = 12'(s1);
        v.s[2] = 12'(s2);
        v.s[3] = 12'(s3);
        v.gap = gap;
        v.exp_num = 4'(n);
        v.exp_state = 2'(st);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [11:0] m);
        bus.sample_valid = 1'b1;
        bus.mic_in = m;
        @(posedge CLK);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    // Sends one window; reports pulse count, pulse at the closing edge and outputs there.
    task automatic send_window(input logic [3:0][11:0] s, input int gap, output int pulses,
                               output logic lv_close, output logic [3:0] n,
                               output logic [1:0] st);
        pulses = 0;
        lv_close = 1'b0;
        n = '0;
        st = '0;
        for (int i = 0; i < 4; i++) begin
            strobe(s[i]);
            if (bus.level_valid) pulses++;
            if (i == 3) begin
                lv_close = bus.level_valid;
                n = bus.num;
                st = bus.LIRO_state;
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge CLK);
                #1;
                if (bus.level_valid) pulses++;
            end
        end
    endtask

    vec_t        vecs[$];
    int          pulses;
    logic        lv_close;
    logic [3:0]  n;
    logic [1:0]  st;
    logic [3:0][11:0] win;

    initial begin
        bus.sample_valid = 1'b0;
        bus.mic_in = 12'd2048;
        #2;
        check("reset_num", bus.num, 0);
        check("reset_state", bus.LIRO_state, 0);
        check("reset_valid", bus.level_valid, 0);
        #10;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

`ifdef VOLUME_PEAK_HOLD_EN
        begin
            int exp_seq[7] = '{12, 12, 12, 11, 11, 11, 10};
            for (int w = 0; w < 7; w++) begin
                for (int i = 0; i < 4; i++) win[i] = (w == 0) ? 12'd3584 : 12'd2048;
                send_window(win, 0, pulses, lv_close, n, st);
                check($sformatf("hold_num_w%0d", w), n, exp_seq[w]);
                check($sformatf("hold_pulse_w%0d", w), lv_close, 1);
            end
            for (int i = 0; i < 4; i++) win[i] = 12'd3840;
            send_window(win, 0, pulses, lv_close, n, st);
            check("hold_jump_num", n, 14);
            check("hold_jump_state", st, 2);
        end
`else
        vecs.push_back(mk(2048, 2300, 2100, 2049, 0, 1, 0));
        vecs.push_back(mk(2048, 2048, 2048, 3500, 0, 11, 2));
        vecs.push_back(mk(2048, 2048, 2048, 2048, 0, 0, 0));
        vecs.push_back(mk(100, 4095, 2048, 2048, 0, 15, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2048, 2048, 2048, 3500, 7, 11, 2));
        vecs.push_back(mk(2816, 2048, 2048, 2048, 3, 6, 1));
        vecs.push_back(mk(2815, 2815, 2815, 2815, 0, 5, 0));
        vecs.push_back(mk(2048, 4094, 2048, 2048, 2, 15, 2));
        vecs.push_back(mk(3456, 3000, 2048, 2048, 0, 11, 2));
        vecs.push_back(mk(3455, 3455, 3455, 3455, 1, 10, 1));
        vecs.push_back(mk(2048, 3000, 3000, 2500, 0, 7, 1));
        foreach (vecs[k]) begin
            send_window(vecs[k].s, vecs[k].gap, pulses, lv_close, n, st);
            check($sformatf("v%0d_num", k), n, vecs[k].exp_num);
            check($sformatf("v%0d_state", k), st, vecs[k].exp_state);
            check($sformatf("v%0d_pulse_at_close", k), lv_close, 1);
            check($sformatf("v%0d_pulse_count", k), pulses, 1);
            repeat (5) @(posedge CLK);
            #1;
            check($sformatf("v%0d_idle_num", k), bus.num, vecs[k].exp_num);
            check($sformatf("v%0d_idle_valid", k), bus.level_valid, 0);
        end
`endif

        // Mid-window reset discards partial progress; start from a clean state first.
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) win[i] = (i == 1) ? 12'd3200 : 12'd2048;
        send_window(win, 0, pulses, lv_close, n, st);
        check("pre_reset_num", n, 9);
        check("pre_reset_state", st, 1);
        strobe(12'd2048);
        strobe(12'd2048);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_num", bus.num, 0);
        check("async_reset_state", bus.LIRO_state, 0);
        check("async_reset_valid", bus.level_valid, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) win[i] = (i == 3) ? 12'd3500 : 12'd2048;
        send_window(win, 0, pulses, lv_close, n, st);
        check("post_reset_pulse_count", pulses, 1);
        check("post_reset_pulse_at_4th", lv_close, 1);
        check("post_reset_num", n, 11);
        check("post_reset_state", st, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
